// File: rtl/serial_logic_unit.sv
// serial_logic_unit: nibble-serial AND/OR/XOR/NOR unit with valid/ready on both sides.
// One NIBBLE-bit slice of the result is produced per cycle; the full WIDTH-bit result
// is presented in DONE until the consumer accepts it.
// Optional feature macro: SERIAL_LOGIC_ZERO_FLAG_EN (registered result==0 flag).
// Without it, zero_o is tied low.
module serial_logic_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NIBBLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int unsigned NSLICE = WIDTH / NIBBLE;
    localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NSLICE - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [NIBBLE-1:0] a_sl, b_sl, res_sl;

    // Select the operand slices addressed by the current slice counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt_q == CntW'(i)) begin
                a_sl = a_q[i*NIBBLE +: NIBBLE];
                b_sl = b_q[i*NIBBLE +: NIBBLE];
            end
        end
    end

    // Apply the latched opcode to the current slice.
    always_comb begin
        case (op_q)
            OpAnd:   res_sl = a_sl & b_sl;
            OpOr:    res_sl = a_sl | b_sl;
            OpXor:   res_sl = a_sl ^ b_sl;
            default: res_sl = ~(a_sl | b_sl);
        endcase
    end

    // Next-state: accept in IDLE, write one slice per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    op_d     = op_i;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CntW'(i)) begin
                        result_d[i*NIBBLE +: NIBBLE] = res_sl;
                    end
                end
                // Counter parks on the last slice rather than wrapping.
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic zero_q, zero_d;

    // Zero flag: cleared on accept, captured from the final result on DONE entry.
    always_comb begin
        zero_d = zero_q;
        if (state_q == StIdle && in_valid_i) begin
            zero_d = 1'b0;
        end else if (state_q == StRun && cnt_q == CntLast) begin
            zero_d = (result_d == '0);
        end
    end

    // Zero flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;
`else
    assign zero_o = 1'b0;
`endif

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: directed + randomized checks of serial_logic_unit against a
// word-level reference model. Honours SERIAL_LOGIC_ZERO_FLAG_EN for the zero flag.
module tb_serial_logic_unit;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NIBBLE = 4;
    localparam int unsigned NSLICE = WIDTH / NIBBLE;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = -1000;

    serial_logic_unit #(
        .WIDTH  (WIDTH),
        .NIBBLE (NIBBLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .zero_o      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Word-level reference: the whole result at once.
    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] o,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic ref_zero(input logic [WIDTH-1:0] r);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        return (r == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Must be entered at a negedge with the unit in IDLE; returns at the negedge
    // right after the release edge. Inputs are scrambled while the op runs.
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input int hold, input int spacing);
        logic [WIDTH-1:0] exp;
        int lat;
        exp = ref_result(o, x, y);
        check_val("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        if (spacing > 0) check_val("accept_spacing", cyc - last_acc, spacing);
        last_acc = cyc;
        in_valid = $urandom_range(0, 1);
        check_val("cleared_on_accept", result, '0);
        check_val("zero_cleared_on_accept", zero, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            check_val("in_ready_low_in_run", in_ready, 0);
            a = $urandom;
            b = $urandom;
            op = 2'($urandom);
            @(negedge clk);
            lat++;
        end
        check_val("latency", lat, NSLICE);
        check_val("result", result, exp);
        check_val("zero", zero, ref_zero(exp));
        check_val("in_ready_low_in_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            check_val("held_out_valid", out_valid, 1);
            check_val("held_result", result, exp);
            check_val("held_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("released_out_valid", out_valid, 0);
        check_val("released_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result, '0);
        check_val("rst_zero", zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // AND
        run_op(2'b00, 32'hF0F01234, 32'h0FF0FFFF, 0, 0);
        @(negedge clk);
        // OR then XOR back-to-back
        run_op(2'b01, 32'h12340000, 32'h00005678, 0, 0);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, NSLICE + 2);
        // NOR with backpressure
        run_op(2'b11, 32'h00000000, 32'h00000000, 5, NSLICE + 2);

        // Random ops, mixed backpressure and idle gaps
        for (int n = 0; n < 25; n++) begin
            logic [1:0] ro;
            logic [WIDTH-1:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = (n % 5 == 0) ? ~ra : $urandom;
            run_op(ro, ra, rb, $urandom_range(0, 3), 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Reset mid-operation
        in_valid = 1'b1;
        op = 2'b01;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_result", result, '0);
        check_val("midrst_zero", zero, 0);
        repeat (3) begin
            @(negedge clk);
            check_val("midrst_hold_out_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'hFFFFFFFF, 32'h0000FFFF, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
